// File: rtl/clk_period_monitor.sv
// clk_period_monitor: measures each div_clk cycle (period, high time) in clk_in cycles and flags ratio errors and stalls.
// Latency: meas_valid is high 2 clk_in cycles after s1 first samples a div_clk rise (s1/s2/s3 then output register).
// Backpressure: none; free-running monitor, each new result overwrites the previous one.
// Optional duty-cycle check: compiled in when CLK_MON_DUTY_CHECK_EN is defined, otherwise duty_err is tied 0.
module clk_period_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 3,
    parameter int TIMEOUT    = 200
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             div_clk,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             period_err,
    output logic             timeout,
    output logic             duty_err
);

    // Two-state measurement FSM
    localparam logic [0:0] ST_ARM  = 1'b0;
    localparam logic [0:0] ST_MEAS = 1'b1;

    localparam logic [CNT_W-1:0] EXP_C = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    // Synchronizer and edge-history flops
    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    // Measurement state
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_hi_q, cnt_hi_d;
    logic [CNT_W-1:0] cnt_lo_q, cnt_lo_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;

    // Registered results
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             meas_valid_q, meas_valid_d;
    logic             period_err_q, period_err_d;
    logic             timeout_q, timeout_d;

    // Decoded events
    logic             rise;
    logic             meas_take;
    logic             tmo_hit;
    logic [CNT_W-1:0] meas_sum;

    // Synchronizer next state: plain shift of the sampled divided clock
    always_comb begin
        s1_d = div_clk;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Synchronizer registers
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // Event decode; a rise coinciding with the timeout threshold wins over the timeout
    always_comb begin
        rise      = s2_q & ~s3_q;
        meas_take = rise && (state_q == ST_MEAS);
        tmo_hit   = (tcnt_q == TMO_C) && !rise;
        // Cannot overflow: the stall timeout fires long before the sum wraps
        meas_sum  = cnt_hi_q + cnt_lo_q;
    end

    // FSM, phase counters, stall counter and result registers next state
    always_comb begin
        state_d      = state_q;
        cnt_hi_d     = cnt_hi_q;
        cnt_lo_d     = cnt_lo_q;
        tcnt_d       = tcnt_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        period_err_d = period_err_q;
        timeout_d    = timeout_q;

        // Stall counter runs in both states and parks at the threshold
        if (rise) begin
            tcnt_d = '0;
        end else if (tcnt_q != TMO_C) begin
            tcnt_d = tcnt_q + ONE_C;
        end

        case (state_q)
            ST_ARM: begin
                // Partial first cycle is discarded; the rise cycle itself is high
                if (rise) begin
                    cnt_hi_d = ONE_C;
                    cnt_lo_d = '0;
                    state_d  = ST_MEAS;
                end
            end
            ST_MEAS: begin
                if (rise) begin
                    period_d     = meas_sum;
                    high_time_d  = cnt_hi_q;
                    meas_valid_d = 1'b1;
                    period_err_d = (meas_sum != EXP_C);
                    timeout_d    = 1'b0;
                    cnt_hi_d     = ONE_C;
                    cnt_lo_d     = '0;
                end else if (s2_q) begin
                    cnt_hi_d = cnt_hi_q + ONE_C;
                end else begin
                    cnt_lo_d = cnt_lo_q + ONE_C;
                end
            end
            default: begin
                state_d  = ST_ARM;
                cnt_hi_d = '0;
                cnt_lo_d = '0;
            end
        endcase

        // Stall: drop back to ARM, keep the last measurement visible
        if (tmo_hit) begin
            timeout_d = 1'b1;
            state_d   = ST_ARM;
            cnt_hi_d  = '0;
            cnt_lo_d  = '0;
        end
    end

    // Measurement state and result registers
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_ARM;
            cnt_hi_q     <= '0;
            cnt_lo_q     <= '0;
            tcnt_q       <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            period_err_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_hi_q     <= cnt_hi_d;
            cnt_lo_q     <= cnt_lo_d;
            tcnt_q       <= tcnt_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            period_err_q <= period_err_d;
            timeout_q    <= timeout_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign period_err = period_err_q;
    assign timeout    = timeout_q;

`ifdef CLK_MON_DUTY_CHECK_EN
    localparam logic [CNT_W:0] DUTY_TOL = (CNT_W+1)'(1);

    logic           duty_err_q, duty_err_d;
    logic [CNT_W:0] twice_hi;
    logic [CNT_W:0] per_ext;
    logic [CNT_W:0] duty_diff;

    // Duty check on the values being registered: |2*high - period| > 1
    always_comb begin
        twice_hi   = {cnt_hi_q, 1'b0};
        per_ext    = {1'b0, meas_sum};
        if (twice_hi >= per_ext) begin
            duty_diff = twice_hi - per_ext;
        end else begin
            duty_diff = per_ext - twice_hi;
        end
        duty_err_d = duty_err_q;
        if (meas_take) begin
            duty_err_d = (duty_diff > DUTY_TOL);
        end
    end

    // Duty flag register, updated together with meas_valid
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            duty_err_q <= 1'b0;
        end else begin
            duty_err_q <= duty_err_d;
        end
    end

    assign duty_err = duty_err_q;
`else
    assign duty_err = 1'b0;
`endif

endmodule
